operand_loader: RTL
===================

Name: operand_loader

Overview:
- Upstream feeder for the 8-operand, 8-bit combinational adder tree.
- Accepts operands serially over a valid/ready stream and assembles frames of NOPS words.
- Presents each complete frame as one parallel, stable bus (operand 0 drives adder input m, operand 7 drives t) until downstream accepts it.
- Double-buffered (ping-pong) so the next frame loads while the current one is held; sustains one word per cycle.

Parameters:
- WIDTH, 8: operand width in bits.
- NOPS, 8: operands per frame; must be a power of two, 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  WIDTH  serial operand.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word.
- in_abort  input  1  discard the partially loaded frame.
- ops  output  NOPS*WIDTH  frame; operand k at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  ops holds a complete frame.
- out_ready  input  1  downstream takes the frame.
- fill  output  log2(NOPS)+1  words in the current write bank.

Behaviour:
- Reset: one clk edge with rst_n=0 clears both banks to 0, full[1:0]=0, wr_sel=0, rd_sel=0, count=0.
- Reset values: out_valid=0, ops=0, fill=0. in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-frame or while holding a frame discards everything. No partial frame is ever emitted.
- Transfer rule: a word transfers on a clk edge with in_valid&in_ready&!in_abort. A frame transfers on out_valid&out_ready.
- in_ready = !full[wr_sel]. It is a registered-state function only, with no combinational path from out_ready.
- Input accept: on a word transfer, bank[wr_sel][count]<=in_data.
  - If count==NOPS-1: full[wr_sel]<=1, wr_sel toggles, count<=0.
  - Otherwise count<=count+1.
- Output: out_valid = full[rd_sel]; ops = bank[rd_sel].
  - ops must be constant while out_valid=1 and not yet accepted.
  - On a frame transfer: full[rd_sel]<=0, rd_sel toggles. The bank contents are kept (no clear).
- Latency: last word accepted at edge N -> out_valid=1 after edge N, when the read bank is that bank.
- Throughput: with out_ready held 1, continuous input yields one frame every NOPS cycles with no bubbles.
- Both banks full: in_ready=0.
  - A frame transfer in that cycle frees a bank; in_ready rises the following cycle (no pass-through).
- Simultaneous completion of the write bank and release of the read bank: both take effect in the same edge. full is updated per index, with no lost update.
- in_abort=1: count<=0. The word presented that cycle is dropped even if in_valid=1 and count==NOPS-1.
  - Full banks and the output side are unaffected.
  - Abort with count==0 is a no-op.
- fill = count.
- No arithmetic is performed here. Sum width and wrap-around remain the adder tree's concern.
- Assertions:
  - ops stable while out_valid&!out_ready.
  - count never reaches NOPS.

Decomposition:
- Shared package:
  - WIDTH and NOPS defaults.
  - IDX_W = log2(NOPS).
  - An operand typedef (logic [WIDTH-1:0]) and a frame typedef (array of NOPS operands), shared with the adder-tree side.
- One natural sub-module: operand_bank.
  - NOPS×WIDTH register file with synchronous write-enable/index and synchronous clear on reset.
  - Flattened read-out bus.
  - Instantiated twice.

Test Plan:
- Reset, then feed 1..8 with out_ready=1 -> out_valid rises one cycle after the 8th accept; ops = 0x0807060504030201; sum downstream 36.
- out_ready=0, stream 16 words (0x10..0x1F) -> in_ready drops after the 16th word; ops=0x1716..10 held stable; raise out_ready -> next frame 0x1F..18 the following cycle; in_ready returns one cycle after the first release.
- Continuous 64 words (0xFF each) with out_ready=1 -> 8 frames on consecutive 8-cycle boundaries, no in_ready deassertion; each frame sums 0xF8 mod 256.
- Load 5 words, pulse in_abort, then load 8 words 0xA0..0xA7 -> only one frame emitted, equal to 0xA7A6..A0; fill returns to 0 on abort.
- in_abort together with the 8th word -> no frame, fill=0; a following full frame emits normally.
- rst_n=0 for one cycle with one bank full and 3 words pending -> out_valid=0, ops=0, fill=0 next cycle; in_ready=1 after release.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader and the adder tree it feeds.
package operand_loader_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NOPS  = 8;
  localparam int unsigned IDX_W     = $clog2(DEF_NOPS);

  typedef logic [DEF_WIDTH-1:0] operand_t;
  typedef operand_t [DEF_NOPS-1:0] frame_t;

endpackage

// File: rtl/operand_bank.sv
// One frame of operand storage: indexed synchronous write, flattened parallel read-out.
module operand_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NOPS  = 8,
  localparam int unsigned IdxW = $clog2(NOPS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [IdxW-1:0]         wr_idx_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  output logic [NOPS*WIDTH-1:0]   rd_data_o
);

  logic [WIDTH-1:0] mem_q [NOPS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NOPS; k++) mem_q[k] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  for (genvar k = 0; k < NOPS; k++) begin : g_flat
    assign rd_data_o[k*WIDTH +: WIDTH] = mem_q[k];
  end

endmodule

// File: rtl/operand_loader.sv
// Ping-pong serial-to-parallel loader: assembles NOPS-word frames and holds each on ops
// until downstream accepts it, while the other bank fills.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NOPS  = DEF_NOPS,
  localparam int unsigned IdxW = $clog2(NOPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_abort,
  output logic [NOPS*WIDTH-1:0] ops,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IdxW:0]         fill
);

  localparam logic [IdxW:0] LastIdx = (IdxW+1)'(NOPS - 1);
  localparam logic [IdxW:0] NopsC   = (IdxW+1)'(NOPS);

  logic [1:0]  full_q, full_d;
  logic        wr_sel_q, wr_sel_d;
  logic        rd_sel_q, rd_sel_d;
  logic [IdxW:0] count_q, count_d;
  logic        word_xfer, frame_xfer;
  logic [NOPS*WIDTH-1:0] bank_rd [2];

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready   = rst_n & ~full_q[wr_sel_q];
  assign out_valid  = full_q[rd_sel_q];
  assign ops        = rd_sel_q ? bank_rd[1] : bank_rd[0];
  assign fill       = count_q;
  assign word_xfer  = in_valid & in_ready & ~in_abort;
  assign frame_xfer = out_valid & out_ready;

  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    count_d  = count_q;
    if (frame_xfer) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
    if (in_abort) begin
      count_d = '0;
    end else if (word_xfer) begin
      if (count_q == LastIdx) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        count_d          = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      count_q  <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      count_q  <= count_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    operand_bank #(
      .WIDTH (WIDTH),
      .NOPS  (NOPS)
    ) u_bank (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wr_en_i   (word_xfer && (wr_sel_q == 1'(b))),
      .wr_idx_i  (count_q[IdxW-1:0]),
      .wr_data_i (in_data),
      .rd_data_o (bank_rd[b])
    );
  end

  a_ops_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(ops));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q < NopsC);

endmodule
